// File: rtl/tron_vga_pkg.sv
// Shared screen geometry, player colours and arbiter state encoding for the tron VGA path.
// Pure declarations; no timing or flow-control behaviour of its own.
package tron_vga_pkg;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int X_MAX = 159;
  localparam int Y_MAX = 119;

  localparam logic [2:0] COL_P1 = 3'b001;
  localparam logic [2:0] COL_P2 = 3'b010;
  localparam logic [2:0] COL_P3 = 3'b100;
  localparam logic [2:0] COL_P4 = 3'b110;
  localparam logic [2:0] COL_BG = 3'b000;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Binary index of a one-hot 4-bit grant (zero when the vector is empty).
  function automatic logic [1:0] rr_index(input logic [3:0] onehot);
    return {onehot[3] | onehot[2], onehot[3] | onehot[1]};
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin pick: first set request after the last winner, cyclically.
// Zero latency; the pointer register lives in the parent.
module rr_arbiter4
  import tron_vga_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [3:0] gnt,
  output logic       vld
);

  logic [1:0] idx;

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + k[1:0];
      if (!vld && req[idx]) begin
        gnt[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the vga_adapter plot port between four players (round-robin, 1-cycle grant latency)
// and a full-screen clear sweep that pre-empts them; held requests simply wait while busy.
module vga_plot_arbiter
  import tron_vga_pkg::X_W, tron_vga_pkg::Y_W, tron_vga_pkg::state_t,
         tron_vga_pkg::ST_ARB, tron_vga_pkg::ST_CLEAR, tron_vga_pkg::COL_BG,
         tron_vga_pkg::rr_index;
#(
  parameter int         X_MAX     = tron_vga_pkg::X_MAX,
  parameter int         Y_MAX     = tron_vga_pkg::Y_MAX,
  parameter logic [2:0] BG_COLOUR = COL_BG
) (
  input  logic           CLOCK_50,
  input  logic           resetn,
  input  logic           clear_req,
  input  logic [3:0]     req,
  input  logic [31:0]    p_x,
  input  logic [27:0]    p_y,
  input  logic [11:0]    p_colour,
  output logic [3:0]     grant,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [2:0]     colour,
  output logic           plot,
  output logic           busy,
  output logic           clear_done
);

  localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);

  state_t         state;
  logic [1:0]     last;
  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;

  logic [3:0]     eligible;
  logic [3:0]     win;
  logic           win_vld;
  logic [1:0]     win_idx;
  logic [X_W-1:0] win_x;
  logic [Y_W-1:0] win_y;
  logic [2:0]     win_col;
  logic           win_ok;

  // Masking the live grant stops a held request from winning two cycles in a row.
  assign eligible = req & ~grant;

  rr_arbiter4 u_rr (
    .req  (eligible),
    .last (last),
    .gnt  (win),
    .vld  (win_vld)
  );

  assign win_idx = rr_index(win);
  assign win_x   = p_x[{win_idx, 3'b000} +: X_W];
  assign win_y   = p_y[32'(win_idx) * Y_W +: Y_W];
  assign win_col = p_colour[32'(win_idx) * 3 +: 3];
  assign win_ok  = (win_x <= X_LIM) && (win_y <= Y_LIM);

  // cx/cy always hold the next clear pixel; the entry cycle emits (0,0) itself.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_ARB;
      last       <= 2'd3;
      cx         <= '0;
      cy         <= '0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      grant      <= '0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      plot       <= 1'b0;
      grant      <= '0;
      clear_done <= 1'b0;
      case (state)
        ST_ARB: begin
          busy <= 1'b0;
          if (clear_req) begin
            state  <= ST_CLEAR;
            x      <= '0;
            y      <= '0;
            colour <= BG_COLOUR;
            plot   <= 1'b1;
            busy   <= 1'b1;
            cx     <= X_W'(1);
            cy     <= '0;
          end else if (win_vld) begin
            grant <= win;
            last  <= win_idx;
            if (win_ok) begin
              x      <= win_x;
              y      <= win_y;
              colour <= win_col;
              plot   <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          x      <= cx;
          y      <= cy;
          colour <= BG_COLOUR;
          plot   <= 1'b1;
          busy   <= 1'b1;
          if (cx == X_LIM) begin
            cx <= '0;
            if (cy == Y_LIM) begin
              cy         <= '0;
              clear_done <= 1'b1;
              state      <= ST_ARB;
            end else begin
              cy <= cy + 1'b1;
            end
          end else begin
            cx <= cx + 1'b1;
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: single grant, round-robin, masking, drop, clear sweep, reset abort.
module tb_vga_plot_arbiter;

  logic        CLOCK_50 = 1'b0;
  logic        resetn;
  logic        clear_req;
  logic [3:0]  req;
  logic [31:0] p_x;
  logic [27:0] p_y;
  logic [11:0] p_colour;
  logic [3:0]  grant;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        clear_done;

  int n_vec = 0;
  int n_err = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  vga_plot_arbiter dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .clear_req  (clear_req),
    .req        (req),
    .p_x        (p_x),
    .p_y        (p_y),
    .p_colour   (p_colour),
    .grant      (grant),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .clear_done (clear_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk_pix(input string tag, input logic [3:0] g, input logic p,
                         input logic [7:0] ex, input logic [6:0] ey, input logic [2:0] ec);
    chk({tag, ".grant"},  32'(grant),  32'(g));
    chk({tag, ".plot"},   32'(plot),   32'(p));
    chk({tag, ".x"},      32'(x),      32'(ex));
    chk({tag, ".y"},      32'(y),      32'(ey));
    chk({tag, ".colour"}, 32'(colour), 32'(ec));
  endtask

  initial begin
    int   ex, ey, n, bad, guard;
    logic seen_done;

    resetn    = 1'b0;
    clear_req = 1'b0;
    req       = 4'b0000;
    p_x       = {8'd70, 8'd50, 8'd30, 8'd10};
    p_y       = {7'd80, 7'd60, 7'd40, 7'd20};
    p_colour  = {3'b110, 3'b100, 3'b010, 3'b001};
    step();
    step();
    chk_pix("reset", 4'b0000, 1'b0, 8'd0, 7'd0, 3'd0);
    chk("reset.busy", 32'(busy), 0);
    chk("reset.done", 32'(clear_done), 0);
    resetn = 1'b1;
    step();

    // Single pixel from player 0, one-cycle request.
    req = 4'b0001;
    step();
    chk_pix("single", 4'b0001, 1'b1, 8'd10, 7'd20, 3'b001);
    req = 4'b0000;
    step();
    chk_pix("single_after", 4'b0000, 1'b0, 8'd10, 7'd20, 3'b001);

    // All four held; pointer last=0 so player 1 leads.
    req = 4'b1111;
    step(); chk_pix("rr1", 4'b0010, 1'b1, 8'd30, 7'd40, 3'b010);
    step(); chk_pix("rr2", 4'b0100, 1'b1, 8'd50, 7'd60, 3'b100);
    step(); chk_pix("rr3", 4'b1000, 1'b1, 8'd70, 7'd80, 3'b110);
    step(); chk_pix("rr4", 4'b0001, 1'b1, 8'd10, 7'd20, 3'b001);
    step(); chk_pix("rr5", 4'b0010, 1'b1, 8'd30, 7'd40, 3'b010);
    req = 4'b0000;
    step(); chk_pix("rr_idle", 4'b0000, 1'b0, 8'd30, 7'd40, 3'b010);

    // Sole held requester is granted on alternate cycles.
    req = 4'b0100;
    step(); chk_pix("alt1", 4'b0100, 1'b1, 8'd50, 7'd60, 3'b100);
    step(); chk_pix("alt2", 4'b0000, 1'b0, 8'd50, 7'd60, 3'b100);
    step(); chk_pix("alt3", 4'b0100, 1'b1, 8'd50, 7'd60, 3'b100);
    step(); chk_pix("alt4", 4'b0000, 1'b0, 8'd50, 7'd60, 3'b100);
    req = 4'b0000;
    step();

    // Off-screen x: grant pulses, pixel dropped, outputs hold.
    p_x[7:0] = 8'd200;
    req = 4'b0001;
    step(); chk_pix("drop", 4'b0001, 1'b0, 8'd50, 7'd60, 3'b100);
    req = 4'b0000;
    p_x[7:0] = 8'd10;
    step();

    // Clear pre-empts a simultaneous request, which is served right after.
    clear_req = 1'b1;
    req = 4'b0001;
    step();
    clear_req = 1'b0;
    ex = 0; ey = 0; n = 0; bad = 0; seen_done = 1'b0;
    for (guard = 0; guard < 20000 && !seen_done; guard++) begin
      if (x !== 8'(ex) || y !== 7'(ey) || colour !== 3'b000 || plot !== 1'b1 ||
          busy !== 1'b1 || grant !== 4'b0000)
        bad++;
      n++;
      if (clear_done === 1'b1) begin
        seen_done = 1'b1;
        if (ex != 159 || ey != 119) bad++;
      end else begin
        if (ex == 159) begin ex = 0; ey++; end
        else ex++;
        step();
      end
    end
    chk("clear.done_seen", 32'(seen_done), 1);
    chk("clear.count", 32'(n), 19200);
    chk("clear.pixel_errors", 32'(bad), 0);
    chk("clear.last_x", 32'(x), 159);
    chk("clear.last_y", 32'(y), 119);
    step();
    chk_pix("post_clear", 4'b0001, 1'b1, 8'd10, 7'd20, 3'b001);
    chk("post_clear.busy", 32'(busy), 0);
    chk("post_clear.done", 32'(clear_done), 0);
    req = 4'b0000;
    step();

    // Reset in the middle of a clear at (80,60).
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (guard = 0; guard < 20000 && !(x === 8'd80 && y === 7'd60); guard++)
      step();
    chk("abort.reached_80_60", 32'({x, y}), 32'({8'd80, 7'd60}));
    resetn = 1'b0;
    #1;
    chk_pix("abort", 4'b0000, 1'b0, 8'd0, 7'd0, 3'd0);
    chk("abort.busy", 32'(busy), 0);
    chk("abort.done", 32'(clear_done), 0);
    step();
    step();
    chk("abort_hold.done", 32'(clear_done), 0);
    resetn = 1'b1;
    step();
    chk("abort_rel.busy", 32'(busy), 0);
    chk("abort_rel.plot", 32'(plot), 0);

    // Pointer back at 3 after reset: player 0 beats player 1.
    req = 4'b0011;
    step(); chk_pix("ptr_rst1", 4'b0001, 1'b1, 8'd10, 7'd20, 3'b001);
    step(); chk_pix("ptr_rst2", 4'b0010, 1'b1, 8'd30, 7'd40, 3'b010);
    chk("ptr_rst.busy", 32'(busy), 0);
    req = 4'b0000;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
